// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// signed ops run on magnitudes and are sign-corrected on the way into DONE.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_e,
  input  logic [2:0]      funct3_e,
  input  logic [XLEN-1:0] src_a_e,
  input  logic [XLEN-1:0] src_b_e,
  input  logic            flush_e,
  output logic            stall_md,
  output logic            result_valid,
  output logic [XLEN-1:0] result_md
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // Handshake: an instruction is taken in IDLE when start_e & !flush_e; the
  // hazard unit holds EX while stall_md=1, and the instruction leaves EX in
  // the single cycle where result_valid=1 (stall_md=0 there).
  state_t              state, state_nx;
  logic [2:0]          op_q;
  logic                sa_q, sb_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q, acc_nx;
  logic [CW-1:0]       count_q;
  logic [XLEN-1:0]     result_q;

  logic                signed_a, signed_b, neg_a, neg_b, is_div;
  logic                div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]     mag_a, mag_b, special_res;
  logic [XLEN:0]       mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0]   mul_nx, div_nx, prod_fix;
  logic [XLEN-1:0]     quo, rem, fix_res;

  // Operand decode for the instruction sitting in EX.
  always_comb begin
    signed_a = (funct3_e == 3'd1) || (funct3_e == 3'd2) ||
               (funct3_e == 3'd4) || (funct3_e == 3'd6);
    signed_b = (funct3_e == 3'd1) || (funct3_e == 3'd4) || (funct3_e == 3'd6);
    neg_a    = signed_a & src_a_e[XLEN-1];
    neg_b    = signed_b & src_b_e[XLEN-1];
    mag_a    = neg_a ? -src_a_e : src_a_e;
    mag_b    = neg_b ? -src_b_e : src_b_e;
    is_div   = funct3_e[2];
    div_zero = (src_b_e == '0);
    div_ovf  = !funct3_e[0] && (src_a_e == {1'b1, {(XLEN-1){1'b0}}}) && (src_b_e == '1);
    special  = is_div && (div_zero || div_ovf);
    if (div_zero) special_res = funct3_e[1] ? src_a_e : '1;
    else          special_res = funct3_e[1] ? '0 : src_a_e;
    accept   = (state == S_IDLE) && start_e && !flush_e;
  end

  // One iteration step: shift-add (low half holds the multiplier) or
  // restoring divide (high half is the partial remainder).
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    div_nx   = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_nx   = (state == S_DIV) ? div_nx : mul_nx;
    prod_fix = (sa_q ^ sb_q) ? -acc_nx : acc_nx;
    quo      = acc_nx[XLEN-1:0];
    rem      = acc_nx[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:              fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:  fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:        fix_res = (sa_q ^ sb_q) ? -quo : quo;
      default:           fix_res = sa_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = special ? S_DONE : (is_div ? S_DIV : S_MUL);
      S_MUL, S_DIV: begin
        if (flush_e)             state_nx = S_IDLE;
        else if (count_q == '0)  state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stall_md     = !flush_e && (((state == S_IDLE) && start_e) ||
                                (state == S_MUL) || (state == S_DIV));
    result_valid = (state == S_DONE) && !flush_e;
    result_md    = result_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= funct3_e;
      sa_q    <= neg_a;
      sb_q    <= neg_b;
      opnd_q  <= is_div ? mag_b : mag_a;
      acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
      count_q <= CW'(XLEN-1);
      if (special) result_q <= special_res;
    end else if (((state == S_MUL) || (state == S_DIV)) && !flush_e) begin
      acc_q <= acc_nx;
      if (count_q == '0) result_q <= fix_res;
      else               count_q  <= count_q - 1'b1;
    end
  end
endmodule
